reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Architectural register file for the MIPS datapath with an integrated pending-write scoreboard. It sits directly downstream of the write-back selection muxes: the 5-bit destination mux drives `wr_addr` and `issue_addr`, and the 32-bit result mux drives `wr_data`. The block provides two combinational read ports with write bypass. Per-register busy bits are set when an instruction issues and cleared at write-back, and the block flags read-after-write hazards to the stall logic.

## Interface
Parameters:
- `DATA_W`, 32, register width.
- `NREG`, 32, number of registers. Fixed at 32; the address width is 5.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs_addr`  in  5  read port A address.
- `rt_addr`  in  5  read port B address.
- `rs_data`  out  32  read port A data, combinational.
- `rt_data`  out  32  read port B data, combinational.
- `wr_en`  in  1  write-back strobe.
- `wr_addr`  in  5  write-back register, from the destination mux.
- `wr_data`  in  32  write-back value, from the result mux.
- `issue_en`  in  1  an instruction with a destination register issues this cycle.
- `issue_addr`  in  5  destination register of the issuing instruction.
- `hazard_rs`  out  1  `rs_addr` has an outstanding write not satisfied this cycle.
- `hazard_rt`  out  1  same for `rt_addr`.
- `busy`  out  32  scoreboard vector; bit i set means register i has a write pending.

## Operation
- **Storage:** 32 × 32-bit registers. Register 0 reads as 0 at all times. Writes to register 0 are discarded. Register 0 is never marked busy.
- **Write:** when `wr_en` is high and `wr_addr` ≠ 0, `regs[wr_addr]` takes `wr_data` on the rising edge.
- **Read:** `rs_data` is 0 if `rs_addr` = 0.
  - Otherwise, if `wr_en` is high and `wr_addr` = `rs_addr`, `rs_data` is `wr_data` (write-through bypass).
  - Otherwise `rs_data` is `regs[rs_addr]`.
  - `rt_data` follows the same rules with `rt_addr`.
- **Scoreboard, per register i ≠ 0, at each edge:**
  - `set` = `issue_en` & (`issue_addr` = i).
  - `clr` = `wr_en` & (`wr_addr` = i).
  - `busy[i]` becomes 1 if `set`, else 0 if `clr`, else holds.
  - When `set` and `clr` hit the same register in the same cycle, set wins: the new producer is outstanding.
  - `busy[0]` is constant 0.
- **Hazard:** `hazard_rs` = (`rs_addr` ≠ 0) & `busy[rs_addr]` & ~(`wr_en` & `wr_addr` = `rs_addr`).
  - The bypassed write satisfies the read in that same cycle.
  - `hazard_rt` is defined the same way with `rt_addr`.
- **Stall interaction:** issue does not see its own busy bit in the same cycle. The stall logic is responsible for not asserting `issue_en` while either hazard output is high.
- **Redundant write:** a write to a register that is not busy is legal. The data is written and `busy` is unchanged (stays 0).

## Timing
- **Reset (`rst_n` low, asynchronous):** all registers go to 0 and `busy` goes to 0 immediately, without waiting for a clock edge. As a result `rs_data`, `rt_data`, `hazard_rs` and `hazard_rt` read 0.
- **Reset release:** takes effect at the first rising edge after `rst_n` goes high. A write or issue presented on that edge is accepted.
- **Reset mid-operation:** all pending busy bits and all register contents are lost. There is no partial-write state.
- **Read latency:** 0 cycles (combinational from the address and write-port inputs).
- **Write latency:** 1 edge. A read in the cycle after the write returns the stored value without the bypass.
- **Issue to busy:** 1 edge. `busy[issue_addr]` is visible in the cycle after `issue_en`.
- **Write-back to busy clear:** the bit clears on the same edge as the write. The hazard is already suppressed combinationally in the write cycle.
- **Paths:** no combinational path from `issue_en`/`issue_addr` to any output. A combinational path exists from `wr_*` to the read data and hazard outputs.

## Test plan
- **Reset:** hold `rst_n` = 0, drive random addresses → `rs_data` = `rt_data` = 0, `busy` = 0, hazards 0. Release, read r5 → 0.
- **Write/read and bypass:**
  - Write r7 = 0xDEADBEEF with `rs_addr` = 7 in the same cycle → `rs_data` = 0xDEADBEEF that cycle via bypass.
  - Next cycle with `wr_en` = 0 → `rs_data` still 0xDEADBEEF.
- **Register 0:** write r0 = 0xFFFFFFFF and issue to r0 → `rs_data`(r0) = 0, `busy[0]` = 0, `hazard_rs` = 0.
- **Scoreboard RAW:**
  - Issue r9 at cycle 0 → `busy[9]` = 1 from cycle 1.
  - Read r9 in cycles 1–3 → `hazard_rs` = 1.
  - Write r9 = 0x1234 at cycle 4 → `hazard_rs` = 0 and `rs_data` = 0x1234 in cycle 4; `busy[9]` = 0 in cycle 5.
- **Simultaneous set/clear:** with r3 busy, issue r3 and write r3 = 0x55 in the same cycle → next cycle `busy[3]` = 1 and `regs[3]` = 0x55. A hazard is reported on r3 until a second write.
- **Asynchronous reset mid-flight:** with `busy` = 0x0000_0404 and r2 = 0xA5A5A5A5, pulse `rst_n` low between edges → `busy` = 0 and r2 reads 0 before the next edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
// Architectural register file (32 x DATA_W) with an integrated pending-write
// scoreboard. Two combinational read ports with write-through bypass, one
// write-back port, and one issue port that marks a destination register busy
// until its write-back arrives. Read-after-write hazards are flagged per port.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst_n       in   asynchronous active-low reset (clears registers and busy)
//   rs_addr     in   read port A address
//   rt_addr     in   read port B address
//   rs_data     out  read port A data (combinational, bypassed)
//   rt_data     out  read port B data (combinational, bypassed)
//   wr_en       in   write-back strobe
//   wr_addr     in   write-back register
//   wr_data     in   write-back value
//   issue_en    in   an instruction with a destination issues this cycle
//   issue_addr  in   destination register of the issuing instruction
//   hazard_rs   out  rs_addr has an outstanding write not satisfied this cycle
//   hazard_rt   out  same for rt_addr
//   busy        out  scoreboard vector, bit i = register i has a write pending
// ----------------------------------------------------------------------------
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        rs_addr,
   input  logic [4:0]        rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_en,
   input  logic [4:0]        issue_addr,
   output logic              hazard_rs,
   output logic              hazard_rt,
   output logic [NREG-1:0]   busy
);

   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_busy;

   logic [NREG-1:0]   w_set;
   logic [NREG-1:0]   w_clr;
   logic [NREG-1:0]   w_busy_nxt;
   logic              w_wr_hit_rs;
   logic              w_wr_hit_rt;

   // One-hot decode of the issue and write-back destinations.
   assign w_set = issue_en ? (NREG'(1) << issue_addr) : '0;
   assign w_clr = wr_en    ? (NREG'(1) << wr_addr)    : '0;

   // Set has priority over clear: a same-cycle issue to the register being
   // written back makes the new producer the outstanding one. Bit 0 is forced
   // low so r0 can never be reported busy.
   assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~NREG'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (wr_en && (wr_addr != 5'd0)) begin
            r_regs[wr_addr] <= wr_data;
         end
         r_busy <= w_busy_nxt;
      end
   end

   // A write in flight this cycle to the register being read.
   assign w_wr_hit_rs = wr_en && (wr_addr == rs_addr);
   assign w_wr_hit_rt = wr_en && (wr_addr == rt_addr);

   assign rs_data = (rs_addr == 5'd0) ? '0 :
                    w_wr_hit_rs       ? wr_data : r_regs[rs_addr];
   assign rt_data = (rt_addr == 5'd0) ? '0 :
                    w_wr_hit_rt       ? wr_data : r_regs[rt_addr];

   // The bypassed write satisfies the read in the same cycle, so it masks
   // the hazard even though the busy bit only clears at the edge.
   assign hazard_rs = (rs_addr != 5'd0) && r_busy[rs_addr] && !w_wr_hit_rs;
   assign hazard_rt = (rt_addr != 5'd0) && r_busy[rt_addr] && !w_wr_hit_rt;

   assign busy = r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed and randomized stimulus for reg_file_sb, checked against an
// array-based reference model of the register file and scoreboard.
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs_addr, rt_addr;
   logic [31:0] rs_data, rt_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic        hazard_rs, hazard_rt;
   logic [31:0] busy;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   bit          m_busy [32];

   reg_file_sb #(.DATA_W(32), .NREG(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .hazard_rs  (hazard_rs),
      .hazard_rt  (hazard_rt),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'h0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Expected read value from the architectural rules.
   function automatic logic [31:0] exp_rd(logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (wr_en && wr_addr == a) return wr_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_haz(logic [4:0] a);
      return (a != 5'd0) && m_busy[a] && !(wr_en && wr_addr == a);
   endfunction

   // Model the effect of one rising edge with the inputs currently applied.
   task automatic model_edge();
      if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (issue_en) m_busy[issue_addr] = 1'b1;
      m_busy[0] = 1'b0;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic [31:0] eb;
      for (int i = 0; i < 32; i++) eb[i] = m_busy[i];
      chk({tag, "_rs_data"},   rs_data,          exp_rd(rs_addr));
      chk({tag, "_rt_data"},   rt_data,          exp_rd(rt_addr));
      chk({tag, "_hazard_rs"}, {31'h0, hazard_rs}, {31'h0, exp_haz(rs_addr)});
      chk({tag, "_hazard_rt"}, {31'h0, hazard_rt}, {31'h0, exp_haz(rt_addr)});
      chk({tag, "_busy"},      busy,             eb);
   endtask

   // Called at posedge+1: apply inputs, check mid-cycle, then take the edge.
   task automatic step(string tag, logic we, logic [4:0] wa, logic [31:0] wd,
                       logic ie, logic [4:0] ia, logic [4:0] ra, logic [4:0] rb);
      wr_en = we; wr_addr = wa; wr_data = wd;
      issue_en = ie; issue_addr = ia;
      rs_addr = ra; rt_addr = rb;
      #4;
      check_all(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0;
      rs_addr = '0; rt_addr = '0;
      model_clear();

      // Held in reset with random read addresses
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rs_addr = 5'($urandom); rt_addr = 5'($urandom);
         #1;
         check_all("reset");
      end

      // Release between edges; first edge after release is live
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("rel_r5", 0, 0, 0, 0, 0, 5'd5, 5'd5);

      // Write r7 with same-cycle bypass, then stored read
      step("byp_r7",   1, 5'd7, 32'hDEADBEEF, 0, 0, 5'd7, 5'd0);
      step("store_r7", 0, 5'd0, 32'h0,        0, 0, 5'd7, 5'd7);
      chk("r7_value", rs_data, 32'hDEADBEEF);

      // Register 0 is immutable and never busy
      step("r0_wr", 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd7);
      step("r0_rd", 0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd0);

      // RAW on r9
      step("raw_iss", 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
      for (int k = 0; k < 3; k++) begin
         step("raw_wait", 0, 0, 0, 0, 0, 5'd9, 5'd9);
      end
      step("raw_wb",   1, 5'd9, 32'h00001234, 0, 0, 5'd9, 5'd9);
      step("raw_done", 0, 0, 0, 0, 0, 5'd9, 5'd9);

      // Simultaneous set and clear on r3
      step("sc_iss",  0, 0, 0, 1, 5'd3, 5'd3, 5'd0);
      step("sc_both", 1, 5'd3, 32'h55, 1, 5'd3, 5'd3, 5'd3);
      step("sc_held", 0, 0, 0, 0, 0, 5'd3, 5'd3);
      chk("sc_hazard_still", {31'h0, hazard_rs}, 32'h1);
      step("sc_wb2",  1, 5'd3, 32'h66, 0, 0, 5'd3, 5'd0);
      step("sc_done", 0, 0, 0, 0, 0, 5'd3, 5'd3);

      // Build busy = 0x404 with r2 = A5A5A5A5, then reset between edges
      step("mf_wr2",  1, 5'd2, 32'hA5A5A5A5, 0, 0, 5'd2, 5'd0);
      step("mf_iss2", 0, 0, 0, 1, 5'd2, 5'd2, 5'd10);
      step("mf_iss10",0, 0, 0, 1, 5'd10, 5'd2, 5'd10);
      rs_addr = 5'd2; rt_addr = 5'd7; issue_en = 1'b0; wr_en = 1'b0;
      #1;
      chk("mf_busy_pre", busy, 32'h0000_0404);
      #1;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_all("mf_reset");
      chk("mf_r2_zero", rs_data, 32'h0);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      step("mf_after", 0, 0, 0, 0, 0, 5'd2, 5'd10);

      // Randomized traffic on a narrow address window to force collisions
      for (int k = 0; k < 400; k++) begin
         logic [4:0] wa, ia, ra, rb;
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
         ia = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
         ra = 5'($urandom_range(0, 7));
         rb = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         step("rand", 1'($urandom_range(0, 1)), wa, $urandom,
              1'($urandom_range(0, 2) == 0), ia, ra, rb);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
